// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl
//   Sequencer for one register-to-register move over the shared bus.
//   A request (src, dst, inc) is taken over a valid/ready handshake, the
//   source is enabled onto the bus for SETTLE_CYCLES cycles, the destination
//   is strobed with LOAD (bus value captured into XFER_DATA on that cycle),
//   the source optionally gets a COUNT pulse, and DONE pulses.
//   Illegal requests (index out of range, src == dst) give one ERROR pulse.
//
// Ports
//   CLOCK, RESET            rising-edge clock, synchronous active-high reset
//   REQ_VALID / REQ_READY   request handshake; READY only while idle
//   REQ_SRC, REQ_DST        register indices (latched on accept)
//   REQ_INC                 post-increment the source after the load
//   BUS_IN                  observed shared bus
//   ENABLE_OUT              one-hot/zero source bus-drive enable
//   LOAD_OUT                one-hot/zero destination load strobe
//   COUNT_OUT               one-hot/zero source increment strobe
//   XFER_DATA               bus value captured on the last LOAD cycle
//   DONE, ERROR             one-cycle completion / rejection pulses
module bus_xfer_ctrl #(
    parameter int NUM_REGS      = 8,
    parameter int SEL_WIDTH     = 3,
    parameter int BUS_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [SEL_WIDTH-1:0] REQ_SRC,
    input  logic [SEL_WIDTH-1:0] REQ_DST,
    input  logic                 REQ_INC,
    input  logic [BUS_WIDTH-1:0] BUS_IN,
    output logic [NUM_REGS-1:0]  ENABLE_OUT,
    output logic [NUM_REGS-1:0]  LOAD_OUT,
    output logic [NUM_REGS-1:0]  COUNT_OUT,
    output logic [BUS_WIDTH-1:0] XFER_DATA,
    output logic                 DONE,
    output logic                 ERROR
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("bus_xfer_ctrl: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_DRIVE,
        S_LOADS,
        S_CNT,
        S_FIN
    } state_t;

    // Latched request; held unchanged for the whole transfer.
    typedef struct packed {
        logic [SEL_WIDTH-1:0] src;
        logic [SEL_WIDTH-1:0] dst;
        logic                 inc;
    } req_t;

    state_t               state_q, state_d;
    req_t                 req_q, req_d;
    logic [3:0]           settle_q, settle_d;
    logic [BUS_WIDTH-1:0] xfer_q, xfer_d;

    logic req_ok;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            req_q    <= '0;
            settle_q <= '0;
            xfer_q   <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            settle_q <= settle_d;
            xfer_q   <= xfer_d;
        end
    end

    // Validation only matters at the accept edge; the result is folded into
    // the next state so no strobe ever depends on the live request inputs.
    always_comb begin
        req_ok = (int'(REQ_SRC) < NUM_REGS) &&
                 (int'(REQ_DST) < NUM_REGS) &&
                 (REQ_SRC != REQ_DST);
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        settle_d = settle_q;
        xfer_d   = xfer_q;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    req_d.src = REQ_SRC;
                    req_d.dst = REQ_DST;
                    req_d.inc = REQ_INC;
                    if (req_ok) begin
                        state_d  = S_DRIVE;
                        settle_d = SETTLE_INIT;
                    end else begin
                        state_d  = S_ERR;
                    end
                end
            end
            S_ERR:   state_d = S_IDLE;
            S_DRIVE: begin
                // '<= 1' rather than '== 1' so a zero count can never wrap.
                if (settle_q <= 4'd1) begin
                    state_d = S_LOADS;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_LOADS: begin
                xfer_d  = BUS_IN;
                state_d = req_q.inc ? S_CNT : S_FIN;
            end
            S_CNT:   state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode purely from registered state and latched indices.
    always_comb begin
        ENABLE_OUT = '0;
        LOAD_OUT   = '0;
        COUNT_OUT  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ENABLE_OUT[i] = (state_q == S_DRIVE || state_q == S_LOADS) &&
                            (int'(req_q.src) == i);
            // dst != src is guaranteed by validation; the extra term keeps
            // LOAD off the driving register even if that ever changed.
            LOAD_OUT[i]   = (state_q == S_LOADS) && (int'(req_q.dst) == i) &&
                            (req_q.dst != req_q.src);
            COUNT_OUT[i]  = (state_q == S_CNT) && (int'(req_q.src) == i);
        end
    end

    assign REQ_READY = (state_q == S_IDLE);
    assign DONE      = (state_q == S_FIN);
    assign ERROR     = (state_q == S_ERR);
    assign XFER_DATA = xfer_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl. Unit 0: NUM_REGS=8, SETTLE_CYCLES=1.
// Unit 1: NUM_REGS=6, SETTLE_CYCLES=4. Expected DONE/ERROR events are queued
// when a request is issued and popped by a monitor when the DUT pulses.
module tb_bus_xfer_ctrl;

    logic clk, rst;
    logic [1:0]       vld, inc;
    logic [1:0][2:0]  src, dst;
    logic [1:0][15:0] bus;
    logic [1:0]       rdy, dn, er;
    logic [1:0][7:0]  en, ld, ct;
    logic [1:0][15:0] xd;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic        dn;
        logic        er;
        logic [15:0] d;
    } ev_t;
    ev_t q0[$];
    ev_t q1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_xfer_ctrl #(.NUM_REGS(8), .SEL_WIDTH(3), .BUS_WIDTH(16), .SETTLE_CYCLES(1)) dut (
        .CLOCK(clk), .RESET(rst),
        .REQ_VALID(vld[0]), .REQ_READY(rdy[0]),
        .REQ_SRC(src[0]), .REQ_DST(dst[0]), .REQ_INC(inc[0]),
        .BUS_IN(bus[0]),
        .ENABLE_OUT(en[0]), .LOAD_OUT(ld[0]), .COUNT_OUT(ct[0]),
        .XFER_DATA(xd[0]), .DONE(dn[0]), .ERROR(er[0])
    );

    bus_xfer_ctrl #(.NUM_REGS(6), .SEL_WIDTH(3), .BUS_WIDTH(16), .SETTLE_CYCLES(4)) dut6 (
        .CLOCK(clk), .RESET(rst),
        .REQ_VALID(vld[1]), .REQ_READY(rdy[1]),
        .REQ_SRC(src[1]), .REQ_DST(dst[1]), .REQ_INC(inc[1]),
        .BUS_IN(bus[1]),
        .ENABLE_OUT(en[1][5:0]), .LOAD_OUT(ld[1][5:0]), .COUNT_OUT(ct[1][5:0]),
        .XFER_DATA(xd[1]), .DONE(dn[1]), .ERROR(er[1])
    );
    assign en[1][7:6] = 2'b00;
    assign ld[1][7:6] = 2'b00;
    assign ct[1][7:6] = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input int u, input string tag,
                           input logic [7:0] e_en, input logic [7:0] e_ld, input logic [7:0] e_ct,
                           input logic e_dn, input logic e_er, input logic e_rdy,
                           input logic [15:0] e_xd);
        chk($sformatf("u%0d.%s.en", u, tag),  32'(en[u]),  32'(e_en));
        chk($sformatf("u%0d.%s.ld", u, tag),  32'(ld[u]),  32'(e_ld));
        chk($sformatf("u%0d.%s.ct", u, tag),  32'(ct[u]),  32'(e_ct));
        chk($sformatf("u%0d.%s.dn", u, tag),  32'(dn[u]),  32'(e_dn));
        chk($sformatf("u%0d.%s.er", u, tag),  32'(er[u]),  32'(e_er));
        chk($sformatf("u%0d.%s.rdy", u, tag), 32'(rdy[u]), 32'(e_rdy));
        chk($sformatf("u%0d.%s.xd", u, tag),  32'(xd[u]),  32'(e_xd));
    endtask

    // Advance to the middle of the next cycle, then check every output.
    task automatic cyc(input int u, input string tag,
                       input logic [7:0] e_en, input logic [7:0] e_ld, input logic [7:0] e_ct,
                       input logic e_dn, input logic e_er, input logic e_rdy,
                       input logic [15:0] e_xd);
        @(negedge clk);
        chk_all(u, tag, e_en, e_ld, e_ct, e_dn, e_er, e_rdy, e_xd);
    endtask

    task automatic push(input int u, input logic d, input logic e, input logic [15:0] v);
        ev_t x;
        x.dn = d; x.er = e; x.d = v;
        if (u == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // Called mid-cycle with READY high; the following edge is cycle 0.
    task automatic issue(input int u, input logic [2:0] s, input logic [2:0] d, input logic i);
        vld[u] = 1'b1; src[u] = s; dst[u] = d; inc[u] = i;
        chk($sformatf("u%0d.issue.rdy", u), 32'(rdy[u]), 32'd1);
        @(posedge clk);
        #1 vld[u] = 1'b0;
    endtask

    task automatic sb_check(input int u);
        ev_t        e;
        logic [1:0] ek;
        logic       has;
        chk($sformatf("u%0d.onehot", u), 32'($onehot0(en[u])), 32'd1);
        chk($sformatf("u%0d.cnt_excl", u), 32'(|(ct[u] & (en[u] | ld[u]))), 32'd0);
        if (dn[u] || er[u]) begin
            has = 1'b0; ek = 2'b00;
            if (u == 0 && q0.size() > 0) begin e = q0.pop_front(); has = 1'b1; end
            if (u == 1 && q1.size() > 0) begin e = q1.pop_front(); has = 1'b1; end
            if (has) ek = {e.dn, e.er};
            chk($sformatf("u%0d.sb_evt", u), 32'({dn[u], er[u]}), 32'(ek));
            if (has && e.dn) chk($sformatf("u%0d.sb_data", u), 32'(xd[u]), 32'(e.d));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int u = 0; u < 2; u++) sb_check(u);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; vld = '0; inc = '0; src = '0; dst = '0; bus = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all(0, "reset", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h0000);
        chk_all(1, "reset", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h0000);
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic move; bus changes around the LOAD cycle pin the capture edge.
        bus[0] = 16'h1111;
        push(0, 1, 0, 16'hBEEF);
        issue(0, 3'd2, 3'd5, 1'b0);
        cyc(0, "basic.c1", 8'h04, 8'h00, 8'h00, 0, 0, 0, 16'h0000);
        cyc(0, "basic.c2", 8'h04, 8'h20, 8'h00, 0, 0, 0, 16'h0000);
        bus[0] = 16'hBEEF;
        cyc(0, "basic.c3", 8'h00, 8'h00, 8'h00, 1, 0, 0, 16'hBEEF);
        bus[0] = 16'h2222;
        cyc(0, "basic.c4", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'hBEEF);

        // Post-increment.
        bus[0] = 16'hA5A5;
        push(0, 1, 0, 16'hA5A5);
        issue(0, 3'd0, 3'd7, 1'b1);
        cyc(0, "inc.c1", 8'h01, 8'h00, 8'h00, 0, 0, 0, 16'hBEEF);
        cyc(0, "inc.c2", 8'h01, 8'h80, 8'h00, 0, 0, 0, 16'hBEEF);
        cyc(0, "inc.c3", 8'h00, 8'h00, 8'h01, 0, 0, 0, 16'hA5A5);
        cyc(0, "inc.c4", 8'h00, 8'h00, 8'h00, 1, 0, 0, 16'hA5A5);
        cyc(0, "inc.c5", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'hA5A5);

        // Reject src == dst.
        push(0, 0, 1, 16'h0000);
        issue(0, 3'd3, 3'd3, 1'b0);
        cyc(0, "same.c1", 8'h00, 8'h00, 8'h00, 0, 1, 0, 16'hA5A5);
        cyc(0, "same.c2", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'hA5A5);

        // Back-to-back with VALID held; second request visible throughout.
        bus[0] = 16'h1234;
        push(0, 1, 0, 16'h1234);
        push(0, 1, 0, 16'h5678);
        vld[0] = 1'b1; src[0] = 3'd3; dst[0] = 3'd4; inc[0] = 1'b0;
        chk("u0.b2b.rdy", 32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1 src[0] = 3'd6; dst[0] = 3'd1; inc[0] = 1'b1;
        cyc(0, "b2b.a1", 8'h08, 8'h00, 8'h00, 0, 0, 0, 16'hA5A5);
        cyc(0, "b2b.a2", 8'h08, 8'h10, 8'h00, 0, 0, 0, 16'hA5A5);
        cyc(0, "b2b.a3", 8'h00, 8'h00, 8'h00, 1, 0, 0, 16'h1234);
        bus[0] = 16'h5678;
        cyc(0, "b2b.a4", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h1234);
        @(posedge clk);
        #1 vld[0] = 1'b0;
        cyc(0, "b2b.b1", 8'h40, 8'h00, 8'h00, 0, 0, 0, 16'h1234);
        cyc(0, "b2b.b2", 8'h40, 8'h02, 8'h00, 0, 0, 0, 16'h1234);
        cyc(0, "b2b.b3", 8'h00, 8'h00, 8'h40, 0, 0, 0, 16'h5678);
        cyc(0, "b2b.b4", 8'h00, 8'h00, 8'h00, 1, 0, 0, 16'h5678);
        cyc(0, "b2b.b5", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h5678);

        // Reset during cycle 1 aborts; no event queued.
        bus[0] = 16'hFACE;
        issue(0, 3'd1, 3'd6, 1'b0);
        cyc(0, "abort.c1", 8'h02, 8'h00, 8'h00, 0, 0, 0, 16'h5678);
        rst = 1'b1;
        cyc(0, "abort.c2", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h0000);
        rst = 1'b0;
        cyc(0, "abort.c3", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h0000);
        cyc(0, "abort.c4", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h0000);

        bus[0] = 16'h0F0F;
        push(0, 1, 0, 16'h0F0F);
        issue(0, 3'd2, 3'd3, 1'b0);
        cyc(0, "fresh.c1", 8'h04, 8'h00, 8'h00, 0, 0, 0, 16'h0000);
        cyc(0, "fresh.c2", 8'h04, 8'h08, 8'h00, 0, 0, 0, 16'h0000);
        cyc(0, "fresh.c3", 8'h00, 8'h00, 8'h00, 1, 0, 0, 16'h0F0F);
        cyc(0, "fresh.c4", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'h0F0F);

        // Unit 1: SETTLE_CYCLES=4.
        bus[1] = 16'hC0DE;
        push(1, 1, 0, 16'hC0DE);
        issue(1, 3'd1, 3'd2, 1'b0);
        for (int k = 1; k <= 4; k++)
            cyc(1, $sformatf("s4.c%0d", k), 8'h02, 8'h00, 8'h00, 0, 0, 0, 16'h0000);
        cyc(1, "s4.c5", 8'h02, 8'h04, 8'h00, 0, 0, 0, 16'h0000);
        cyc(1, "s4.c6", 8'h00, 8'h00, 8'h00, 1, 0, 0, 16'hC0DE);
        cyc(1, "s4.c7", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'hC0DE);

        // Unit 1: out-of-range indices with NUM_REGS=6.
        push(1, 0, 1, 16'h0000);
        issue(1, 3'd0, 3'd6, 1'b0);
        cyc(1, "dst6.c1", 8'h00, 8'h00, 8'h00, 0, 1, 0, 16'hC0DE);
        cyc(1, "dst6.c2", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'hC0DE);
        push(1, 0, 1, 16'h0000);
        issue(1, 3'd7, 3'd2, 1'b1);
        cyc(1, "src7.c1", 8'h00, 8'h00, 8'h00, 0, 1, 0, 16'hC0DE);
        cyc(1, "src7.c2", 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'hC0DE);

        repeat (3) @(negedge clk);
        chk("u0.sb_left", 32'(q0.size()), 32'd0);
        chk("u1.sb_left", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Bus-side sequencer that drives the per-register ENABLE/LOAD/COUNT strobes of the shared-bus registers.
- Accepts a transfer request (source index, destination index, optional post-increment) over a valid/ready handshake.
- Enables the source onto the bus, waits for the bus to settle, strobes LOAD on the destination, optionally pulses COUNT on the source, then reports completion.
- Sits between the control unit and the register file / bus fabric.

Parameters:
- NUM_REGS, 8: number of attached registers; strobe vector width.
- SEL_WIDTH, 3: width of the source/destination index fields.
- BUS_WIDTH, 16: data bus width.
- SETTLE_CYCLES, 1: cycles ENABLE is held before LOAD; legal range 1..15.

Ports:
- CLOCK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller idle; a request is accepted when VALID and READY are both high at a rising edge.
- REQ_SRC  in  SEL_WIDTH  index of the register to drive the bus.
- REQ_DST  in  SEL_WIDTH  index of the register to load from the bus.
- REQ_INC  in  1  pulse COUNT on the source after the load.
- BUS_IN  in  BUS_WIDTH  observed shared bus.
- ENABLE_OUT  out  NUM_REGS  one-hot or zero; source bus-drive enable.
- LOAD_OUT  out  NUM_REGS  one-hot or zero; destination load strobe.
- COUNT_OUT  out  NUM_REGS  one-hot or zero; source increment strobe.
- XFER_DATA  out  BUS_WIDTH  bus value captured on the LOAD cycle.
- DONE  out  1  one-cycle pulse on successful completion.
- ERROR  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: state=IDLE; ENABLE_OUT, LOAD_OUT, COUNT_OUT, DONE, ERROR = 0; XFER_DATA=0; REQ_READY=1. All outputs hold these values from the cycle after RESET is sampled high.
- Reset mid-operation aborts the transfer immediately. No further strobes are issued and no DONE pulse follows.
- All outputs are decoded from registered state and registered latched indices. No combinational path runs from request inputs to strobes.
- REQ_READY=1 only in IDLE.
- On acceptance, SRC, DST and INC are latched. Request inputs are ignored at every other time.
- Validation at acceptance: reject if SRC>=NUM_REGS, DST>=NUM_REGS, or SRC==DST.
- States:
  - IDLE: READY=1. Accept -> ERR if invalid, else DRIVE with settle counter=SETTLE_CYCLES.
  - ERR: ERROR=1, READY=0, no strobes -> IDLE. DONE is not asserted.
  - DRIVE: ENABLE_OUT[src]=1. Counter decrements each cycle; when it reaches 1 -> LOADS. DRIVE lasts exactly SETTLE_CYCLES cycles.
  - LOADS: ENABLE_OUT[src]=1 and LOAD_OUT[dst]=1 for exactly one cycle. At this cycle's closing edge, XFER_DATA<=BUS_IN. Next state: CNT if INC, else FIN.
  - CNT: COUNT_OUT[src]=1, ENABLE deasserted, one cycle -> FIN.
  - FIN: DONE=1, READY=0, one cycle -> IDLE.
- Latency, accept edge = cycle 0:
  - no INC: 1+SETTLE_CYCLES+1 cycles to FIN, i.e. DONE in cycle SETTLE_CYCLES+2.
  - INC: one extra cycle.
  - error: ERROR in cycle 1.
  - READY returns in the cycle after DONE or ERROR. Minimum spacing between back-to-back accepts is SETTLE_CYCLES+3 cycles (no INC).
- Invariants:
  - At most one ENABLE_OUT bit is set in any cycle.
  - LOAD_OUT is never set for the source index.
  - COUNT_OUT is never concurrent with ENABLE_OUT or LOAD_OUT.
- XFER_DATA holds its value until the next successful LOADS cycle.
- Settle counter width is 4 bits and never wraps; SETTLE_CYCLES outside 1..15 is illegal.

Test Plan:
- Basic transfer, SETTLE=1: SRC=2, DST=5, INC=0, bus=16'hBEEF -> ENABLE_OUT=8'h04 in cycles 1-2, LOAD_OUT=8'h20 in cycle 2, DONE in cycle 3, XFER_DATA=16'hBEEF, READY high in cycle 4.
- Post-increment: SRC=0, DST=7, INC=1 -> LOAD_OUT=8'h80 in cycle 2, COUNT_OUT=8'h01 with ENABLE_OUT=0 in cycle 3, DONE in cycle 4.
- Rejects: SRC=DST=3 -> ERROR in cycle 1, all strobes 0, DONE never asserted. With NUM_REGS=6, DST=6 -> same response.
- SETTLE_CYCLES=4: SRC=1, DST=2 -> ENABLE_OUT=8'h02 for cycles 1-5, LOAD in cycle 5 only, DONE in cycle 6.
- Back-to-back with VALID held high: second request accepted at the first READY edge after DONE. Its inputs are ignored during the first transfer, and the one-hot invariant holds every cycle.
- RESET asserted in cycle 1 of a transfer -> all strobes 0 from cycle 2, no DONE, READY=1, XFER_DATA=0. A fresh request afterwards completes normally.
